// File: rtl/oam_dma_pkg.sv
// -----------------------------------------------------------------------------
// oam_dma_pkg
//   Shared definitions for the sprite OAM DMA engine: bus read/write
//   encoding, default register addresses, the FSM state type and the
//   trigger-decode helper used by the top level.
// -----------------------------------------------------------------------------
package oam_dma_pkg;

  // Bus direction encoding used across the CPU-side bus.
  localparam logic BUS_R = 1'b1;
  localparam logic BUS_W = 1'b0;

  // Default trigger register and destination port addresses.
  localparam logic [15:0] DMA_REG_ADDR_DEF  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;

  // Index of the final byte in a 256-byte page.
  localparam logic [7:0] LAST_IDX = 8'hFF;

  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_HALT,
    DMA_ALIGN,
    DMA_READ,
    DMA_WRITE
  } dma_state_e;

  // A trigger is a CPU write (never a read) to the DMA register.
  function automatic logic is_trigger(input logic [15:0] a,
                                      input logic        rw,
                                      input logic [15:0] reg_addr);
    return (a == reg_addr) && (rw == BUS_W);
  endfunction

endpackage

// File: rtl/oam_dma_addr_gen.sv
// -----------------------------------------------------------------------------
// oam_dma_addr_gen
//   Source address generator for the OAM DMA: holds the source page and the
//   byte index within it. The index is 8 bits and never carries into the
//   page, so a transfer always stays inside $XX00-$XXFF.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   load         - capture load_page and restart the index at 0
//   load_page    - source page latched on load
//   incr         - advance the index by one
//   page, idx    - current source page and byte index
//   last         - index has reached the final byte of the page
// -----------------------------------------------------------------------------
module oam_dma_addr_gen
  import oam_dma_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_page,
  input  logic       incr,
  output logic [7:0] page,
  output logic [7:0] idx,
  output logic       last
);

  logic [7:0] page_q, page_d;
  logic [7:0] idx_q,  idx_d;

  // Load takes priority so a new transfer always starts cleanly at byte 0.
  always_comb begin
    page_d = page_q;
    idx_d  = idx_q;
    if (load) begin
      page_d = load_page;
      idx_d  = 8'h00;
    end else if (incr) begin
      idx_d  = idx_q + 8'h01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      page_q <= 8'h00;
      idx_q  <= 8'h00;
    end else begin
      page_q <= page_d;
      idx_q  <= idx_d;
    end
  end

  assign page = page_q;
  assign idx  = idx_q;
  assign last = (idx_q == LAST_IDX);

endmodule

// File: rtl/oam_dma.sv
// -----------------------------------------------------------------------------
// oam_dma
//   Sprite OAM DMA engine. Snoops CPU writes to the DMA register; on a hit it
//   stalls the core via rdy, takes the bus and copies 256 bytes from page
//   $XX00-$XXFF to the OAM data port, alternating READ (get cycle) and
//   WRITE (put cycle). The bus is handed back once the last byte is written.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   cpu_a/rw/d   - snooped CPU address, direction (R=1, W=0) and write data
//   bus_d_in     - read data from the memory bus (single-cycle memory)
//   rdy          - core run enable, 0 stalls the core
//   bus_sel      - this block owns the bus
//   bus_a/rw     - DMA address and direction
//   bus_d_out    - DMA write data (always the byte buffer)
// -----------------------------------------------------------------------------
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
  parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_a,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_d,
  input  logic [7:0]  bus_d_in,
  output logic        rdy,
  output logic        bus_sel,
  output logic [15:0] bus_a,
  output logic        bus_rw,
  output logic [7:0]  bus_d_out
);

  dma_state_e state_q, state_d;
  logic       parity_q, parity_d;
  logic [7:0] data_buf_q, data_buf_d;

  logic       addr_load;
  logic       addr_incr;
  logic [7:0] page;
  logic [7:0] idx;
  logic       idx_last;

  oam_dma_addr_gen u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (addr_load),
    .load_page (cpu_d),
    .incr      (addr_incr),
    .page      (page),
    .idx       (idx),
    .last      (idx_last)
  );

  // Get/put phase: parity 0 is a get cycle, parity 1 a put cycle.
  assign parity_d = ~parity_q;

  // Next-state logic. HALT looks at the current parity to decide whether the
  // following cycle is already a get cycle; if not, ALIGN burns one cycle so
  // every READ lands on a get cycle.
  always_comb begin
    state_d    = state_q;
    data_buf_d = data_buf_q;
    addr_load  = 1'b0;
    addr_incr  = 1'b0;
    case (state_q)
      DMA_IDLE: begin
        if (is_trigger(cpu_a, cpu_rw, DMA_REG_ADDR)) begin
          addr_load = 1'b1;
          state_d   = DMA_HALT;
        end
      end
      DMA_HALT: begin
        state_d = parity_q ? DMA_READ : DMA_ALIGN;
      end
      DMA_ALIGN: begin
        state_d = DMA_READ;
      end
      DMA_READ: begin
        data_buf_d = bus_d_in;
        state_d    = DMA_WRITE;
      end
      DMA_WRITE: begin
        if (idx_last) begin
          state_d = DMA_IDLE;
        end else begin
          addr_incr = 1'b1;
          state_d   = DMA_READ;
        end
      end
      default: begin
        state_d = DMA_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DMA_IDLE;
      parity_q   <= 1'b0;
      data_buf_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      parity_q   <= parity_d;
      data_buf_q <= data_buf_d;
    end
  end

  // Outputs decode only flops (state, page/idx, buffer), so nothing on the
  // CPU side reaches them combinationally.
  assign rdy       = (state_q == DMA_IDLE);
  assign bus_sel   = (state_q == DMA_READ) || (state_q == DMA_WRITE);
  assign bus_a     = (state_q == DMA_WRITE) ? OAM_DATA_ADDR : {page, idx};
  assign bus_rw    = (state_q == DMA_WRITE) ? BUS_W : BUS_R;
  assign bus_d_out = data_buf_q;

endmodule

// File: tb/tb_oam_dma.sv
// -----------------------------------------------------------------------------
// tb_oam_dma
//   Self-checking bench for oam_dma. A 64 KiB memory model answers DMA reads;
//   a monitor compares every DMA bus cycle against read/write scoreboards
//   filled when a trigger is driven.
// -----------------------------------------------------------------------------
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_a;
  logic        cpu_rw;
  logic [7:0]  cpu_d;
  logic [7:0]  bus_d_in;
  logic        rdy;
  logic        bus_sel;
  logic [15:0] bus_a;
  logic        bus_rw;
  logic [7:0]  bus_d_out;

  logic [7:0]  mem [0:65535];

  int checks = 0;
  int errors = 0;
  int zero_reads = 0;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_exp_t;

  typedef struct {
    logic [15:0] a;
    logic        rw;
    logic [7:0]  d;
    logic        exp_rdy;
    logic        exp_sel;
  } vec_t;

  wr_exp_t     wr_q [$];
  logic [15:0] rd_q [$];
  wr_exp_t     mon_e;
  logic        tb_parity;

  oam_dma dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_a     (cpu_a),
    .cpu_rw    (cpu_rw),
    .cpu_d     (cpu_d),
    .bus_d_in  (bus_d_in),
    .rdy       (rdy),
    .bus_sel   (bus_sel),
    .bus_a     (bus_a),
    .bus_rw    (bus_rw),
    .bus_d_out (bus_d_out)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Single-cycle memory: read data follows the DMA address directly.
  assign bus_d_in = mem[bus_a];

  // Reference get/put phase, counted from reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_parity <= 1'b0;
    else        tb_parity <= ~tb_parity;
  end

  // Single comparison point: counts every check and reports mismatches.
  function automatic void checkOutput(input string name,
                                      input logic [31:0] actual,
                                      input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endfunction

  task automatic applyStimulus(input logic [15:0] a, input logic rw,
                               input logic [7:0] d);
    cpu_a  = a;
    cpu_rw = rw;
    cpu_d  = d;
  endtask

  // Bus monitor: sampled on the falling edge, away from the active edge.
  // Reads must hit the next scheduled source address on a get cycle; writes
  // must carry the next scheduled byte to the OAM port.
  always @(negedge clk) begin
    if (rst_n && bus_sel) begin
      if (bus_rw) begin
        if (bus_a == 16'h0000) zero_reads++;
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL read_unexpected: got addr %0h, expected no read", bus_a);
        end else begin
          checkOutput("read_addr", bus_a, rd_q.pop_front());
        end
        checkOutput("read_parity", tb_parity, 0);
      end else begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL write_unexpected: got addr %0h data %0h, expected no write",
                   bus_a, bus_d_out);
        end else begin
          mon_e = wr_q.pop_front();
          checkOutput("write_addr", bus_a, mon_e.addr);
          checkOutput("write_data", bus_d_out, mon_e.data);
        end
      end
    end
  end

  // Drives a trigger write in the current cycle and schedules the 256
  // expected reads/writes. READ can only start on a get cycle, so a trigger
  // on a put cycle needs an extra ALIGN cycle.
  task automatic startTransfer(input logic [7:0] page, output int exp_len);
    exp_len = tb_parity ? 514 : 513;
    for (int i = 0; i < 256; i++) begin
      rd_q.push_back({page, i[7:0]});
      wr_q.push_back('{addr: 16'h2004, data: mem[{page, i[7:0]}]});
    end
    applyStimulus(16'h4014, 1'b0, page);
  endtask

  // Full transfer: measures how long rdy stays low and ends on the falling
  // edge of the first IDLE cycle, so a caller can trigger again at once.
  task automatic runTransfer(input logic [7:0] page);
    int exp_len;
    int len;
    startTransfer(page, exp_len);
    @(negedge clk);
    applyStimulus(16'h0000, 1'b1, 8'h00);
    checkOutput("rdy_fall", rdy, 0);
    len = 0;
    while (rdy === 1'b0 && len < 600) begin
      len++;
      @(negedge clk);
    end
    checkOutput("rdy_low_cycles", len, exp_len);
    checkOutput("rdy_after", rdy, 1);
    checkOutput("writes_drained", wr_q.size(), 0);
    checkOutput("reads_drained", rd_q.size(), 0);
  endtask

  task automatic waitParity(input logic p);
    int n;
    n = 0;
    while (tb_parity !== p && n < 4) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    vec_t vecs [6];
    int   wcount;
    int   cyc;

    vecs[0] = '{a: 16'h4014, rw: 1'b1, d: 8'h02, exp_rdy: 1'b1, exp_sel: 1'b0};
    vecs[1] = '{a: 16'h4015, rw: 1'b0, d: 8'h02, exp_rdy: 1'b1, exp_sel: 1'b0};
    vecs[2] = '{a: 16'h4013, rw: 1'b0, d: 8'h05, exp_rdy: 1'b1, exp_sel: 1'b0};
    vecs[3] = '{a: 16'h2004, rw: 1'b0, d: 8'h11, exp_rdy: 1'b1, exp_sel: 1'b0};
    vecs[4] = '{a: 16'h0014, rw: 1'b0, d: 8'h02, exp_rdy: 1'b1, exp_sel: 1'b0};
    vecs[5] = '{a: 16'hC014, rw: 1'b0, d: 8'h02, exp_rdy: 1'b1, exp_sel: 1'b0};

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = i[7:0] ^ 8'hA5;

    // Reset values while reset is held.
    rst_n = 1'b0;
    applyStimulus(16'h0000, 1'b1, 8'h00);
    #12;
    checkOutput("reset_rdy", rdy, 1);
    checkOutput("reset_bus_sel", bus_sel, 0);
    checkOutput("reset_bus_a", bus_a, 16'h0000);
    checkOutput("reset_bus_rw", bus_rw, 1);
    checkOutput("reset_bus_d_out", bus_d_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Non-trigger accesses must leave the engine idle.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].a, vecs[i].rw, vecs[i].d);
      @(negedge clk);
      applyStimulus(16'h0000, 1'b1, 8'h00);
      checkOutput($sformatf("vec%0d_rdy", i), rdy, vecs[i].exp_rdy);
      checkOutput($sformatf("vec%0d_bus_sel", i), bus_sel, vecs[i].exp_sel);
    end

    // Trigger on a get cycle: no ALIGN.
    waitParity(1'b0);
    runTransfer(8'h02);

    // Trigger on a put cycle: one ALIGN, then back-to-back retrigger in the
    // very first IDLE cycle after completion.
    @(negedge clk);
    waitParity(1'b1);
    runTransfer(8'h02);
    runTransfer(8'h07);

    // Top page: addresses must stay within $FF00-$FFFF.
    @(negedge clk);
    runTransfer(8'hFF);
    checkOutput("page_ff_no_zero_read", zero_reads, 0);

    // Reset asserted during the WRITE of idx $40.
    @(negedge clk);
    startTransfer(8'h02, cyc);
    @(negedge clk);
    applyStimulus(16'h0000, 1'b1, 8'h00);
    wcount = 0;
    cyc = 0;
    while (cyc < 400) begin
      if (bus_sel && !bus_rw) begin
        if (wcount == 64) break;
        wcount++;
      end
      @(negedge clk);
      cyc++;
    end
    checkOutput("abort_write_index", wcount, 64);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_rdy", rdy, 1);
    checkOutput("abort_bus_sel", bus_sel, 0);
    checkOutput("abort_bus_a", bus_a, 16'h0000);
    checkOutput("abort_bus_rw", bus_rw, 1);
    checkOutput("abort_bus_d_out", bus_d_out, 8'h00);
    wr_q.delete();
    rd_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_abort_rdy", rdy, 1);
    runTransfer(8'h03);

    @(negedge clk);
    checkOutput("final_bus_sel", bus_sel, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
